// File: rtl/i2c_target_regif_pkg.sv
// Shared definitions for the I2C register-interface target: widths, bus constants,
// FSM state encoding and pointer arithmetic.
package i2c_target_regif_pkg;

    localparam int unsigned DATA_W        = 8;
    localparam int unsigned CNT_W         = 4;
    localparam int unsigned BITS_PER_BYTE = 8;

    // SDA level meanings on the ACK clock and the R/W bit of the address byte
    localparam logic I2C_ACK     = 1'b0;
    localparam logic I2C_NACK    = 1'b1;
    localparam logic I2C_RW_READ = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } state_t;

    // Register pointer auto-increment, wrapping 8'hFF -> 8'h00
    function automatic logic [DATA_W-1:0] ptr_inc(input logic [DATA_W-1:0] ptr);
        return ptr + DATA_W'(1);
    endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes raw SCL/SDA into clk and produces registered SCL edge and
// START/STOP condition pulses plus the synchronized SDA level.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   scl_n;
    logic                   sda_n;

    assign scl_n = scl_sync[SYNC_STAGES-1];
    assign sda_n = sda_sync[SYNC_STAGES-1];

    // Reset to the idle-bus level so release of reset never fakes an edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_s     <= 1'b1;
            sda_s     <= 1'b1;
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_s     <= scl_n;
            sda_s     <= sda_n;
            scl_rise  <= scl_n & ~scl_s;
            scl_fall  <= ~scl_n & scl_s;
            start_det <= scl_n & scl_s & sda_s & ~sda_n;
            stop_det  <= scl_n & scl_s & ~sda_s & sda_n;
        end
    end

endmodule

// File: rtl/i2c_target_regif.sv
// I2C target with 7-bit address, 8-bit auto-incrementing register pointer and a
// strobe-based register-file port toward the host logic.
module i2c_target_regif #(
    parameter logic [6:0]  DEV_ADDR    = 7'h50,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    import i2c_target_regif_pkg::*;

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic sda_s;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_bus_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    bit_cnt_nxt;
    logic [CNT_W-1:0]    cnt_inc;
    logic                last_bit;
    logic [DATA_W-1:0]   shift;
    logic [DATA_W-1:0]   shift_nxt;
    logic [DATA_W-1:0]   byte_in;
    logic                rw;
    logic                rw_nxt;
    logic                rd_pend;
    logic                rd_pend_nxt;
    logic                ld_q;
    logic                sda_oe_nxt;
    logic [DATA_W-1:0]   reg_addr_nxt;
    logic [DATA_W-1:0]   reg_wdata_nxt;
    logic                reg_we_nxt;
    logic                reg_re_nxt;
    logic                busy_nxt;

    assign cnt_inc  = bit_cnt + CNT_W'(1);
    assign last_bit = (cnt_inc == CNT_W'(BITS_PER_BYTE));
    assign byte_in  = {shift[DATA_W-2:0], sda_s};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ld_q marks the clk on which reg_rdata answers the previous reg_re
    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_cnt   <= '0;
            shift     <= '0;
            rw        <= 1'b0;
            rd_pend   <= 1'b0;
            ld_q      <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            rw        <= rw_nxt;
            rd_pend   <= rd_pend_nxt;
            ld_q      <= reg_re;
            sda_oe    <= sda_oe_nxt;
            reg_addr  <= reg_addr_nxt;
            reg_wdata <= reg_wdata_nxt;
            reg_we    <= reg_we_nxt;
            reg_re    <= reg_re_nxt;
            busy      <= busy_nxt;
        end
    end

    // ACK states use sda_oe as the phase bit: first SCL fall drives, second releases
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        rw_nxt        = rw;
        rd_pend_nxt   = rd_pend;
        sda_oe_nxt    = sda_oe;
        reg_addr_nxt  = reg_addr;
        reg_wdata_nxt = reg_wdata;
        reg_we_nxt    = 1'b0;
        reg_re_nxt    = 1'b0;
        busy_nxt      = busy;

        if (start_det) begin
            state_nxt   = ST_ADDR;
            bit_cnt_nxt = '0;
            shift_nxt   = '0;
            rd_pend_nxt = 1'b0;
            sda_oe_nxt  = 1'b0;
        end else if (stop_det) begin
            state_nxt   = ST_IDLE;
            bit_cnt_nxt = '0;
            rd_pend_nxt = 1'b0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    sda_oe_nxt = 1'b0;
                end

                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_nxt   = byte_in;
                        bit_cnt_nxt = cnt_inc;
                        if (last_bit) begin
                            bit_cnt_nxt = '0;
                            if (byte_in[DATA_W-1:1] == DEV_ADDR) begin
                                state_nxt = ST_ADDR_ACK;
                                rw_nxt    = byte_in[0];
                                busy_nxt  = 1'b1;
                            end else begin
                                state_nxt = ST_IGNORE;
                                busy_nxt  = 1'b0;
                            end
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nxt = ~I2C_ACK;
                        end else begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = '0;
                            if (rw == I2C_RW_READ) begin
                                state_nxt  = ST_RDATA;
                                reg_re_nxt = 1'b1;
                            end else begin
                                state_nxt = ST_PTR;
                            end
                        end
                    end
                end

                ST_PTR: begin
                    if (scl_rise) begin
                        shift_nxt   = byte_in;
                        bit_cnt_nxt = cnt_inc;
                        if (last_bit) begin
                            bit_cnt_nxt  = '0;
                            reg_addr_nxt = byte_in;
                            state_nxt    = ST_PTR_ACK;
                        end
                    end
                end

                ST_PTR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nxt = ~I2C_ACK;
                        end else begin
                            sda_oe_nxt  = 1'b0;
                            bit_cnt_nxt = '0;
                            state_nxt   = ST_WDATA;
                        end
                    end
                end

                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_nxt   = byte_in;
                        bit_cnt_nxt = cnt_inc;
                        if (last_bit) begin
                            bit_cnt_nxt   = '0;
                            reg_wdata_nxt = byte_in;
                            reg_we_nxt    = 1'b1;
                            state_nxt     = ST_WDATA_ACK;
                        end
                    end
                end

                ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_nxt = ~I2C_ACK;
                        end else begin
                            sda_oe_nxt   = 1'b0;
                            bit_cnt_nxt  = '0;
                            reg_addr_nxt = ptr_inc(reg_addr);
                            state_nxt    = ST_WDATA;
                        end
                    end
                end

                // rd_pend: master ACKed, next SCL fall requests the following byte
                ST_RDATA: begin
                    if (ld_q) begin
                        shift_nxt  = reg_rdata;
                        sda_oe_nxt = ~reg_rdata[DATA_W-1];
                    end else if (scl_fall) begin
                        if (rd_pend) begin
                            rd_pend_nxt = 1'b0;
                            reg_re_nxt  = 1'b1;
                            bit_cnt_nxt = '0;
                        end else if (last_bit) begin
                            sda_oe_nxt   = 1'b0;
                            bit_cnt_nxt  = '0;
                            reg_addr_nxt = ptr_inc(reg_addr);
                            state_nxt    = ST_RDATA_ACK;
                        end else begin
                            bit_cnt_nxt = cnt_inc;
                            shift_nxt   = {shift[DATA_W-2:0], 1'b0};
                            sda_oe_nxt  = ~shift[DATA_W-2];
                        end
                    end
                end

                ST_RDATA_ACK: begin
                    sda_oe_nxt = 1'b0;
                    if (scl_rise) begin
                        if (sda_s == I2C_NACK) begin
                            state_nxt = ST_IGNORE;
                            busy_nxt  = 1'b0;
                        end else begin
                            state_nxt   = ST_RDATA;
                            rd_pend_nxt = 1'b1;
                        end
                    end
                end

                ST_IGNORE: begin
                    sda_oe_nxt = 1'b0;
                end

                default: begin
                    state_nxt  = ST_IDLE;
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target_regif.sv
// Bench for i2c_target_regif: a bit-banged I2C master plus scoreboard queues for
// register strobes and bus-level ACK/read-data observations.
module tb_i2c_target_regif;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int oe_hi_cnt = 0;
    int busy_hi_cnt = 0;

    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_re_q[$];
    int          exp_bus_q[$];
    int          act_bus_q[$];

    // Open-drain bus and a register file whose contents are addr ^ 8'hFF
    assign scl_in    = scl_m;
    assign sda_in    = sda_m & ~sda_oe;
    assign reg_rdata = reg_addr ^ 8'hFF;

    always #5 clk = ~clk;

    i2c_target_regif #(
        .DEV_ADDR    (7'h50),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT or bus presents a result
    always @(negedge clk) begin : mon
        int a;
        if (sda_oe === 1'b1) oe_hi_cnt++;
        if (busy === 1'b1) busy_hi_cnt++;
        if (rst && reg_we === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_we: got addr 0x%0h data 0x%0h, expected no write", reg_addr, reg_wdata);
            end else begin
                chk("we_addr_data", int'({reg_addr, reg_wdata}), int'(exp_wr_q.pop_front()));
            end
        end
        if (rst && reg_re === 1'b1) begin
            if (exp_re_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_re: got addr 0x%0h, expected no read", reg_addr);
            end else begin
                chk("re_addr", int'(reg_addr), int'(exp_re_q.pop_front()));
            end
        end
        while (act_bus_q.size() > 0) begin
            a = act_bus_q.pop_front();
            if (exp_bus_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_bus: got 0x%0h, expected nothing", a);
            end else begin
                chk("bus", a, exp_bus_q.pop_front());
            end
        end
    end

    task automatic m_start();
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(2 * Q);
        sda_m = 1'b0;
        wait_clk(2 * Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic m_stop();
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(2 * Q);
        sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic m_bit(input logic b);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(2 * Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic m_rbit(output logic r);
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        r = sda_in;
        wait_clk(Q);
        scl_m = 1'b0;
        wait_clk(Q);
    endtask

    // Sends a byte and records the ACK level seen (0 = ACK)
    task automatic m_wbyte(input logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) m_bit(b[i]);
        m_rbit(r);
        act_bus_q.push_back(int'(r));
    endtask

    task automatic m_rbyte(input logic nack);
        logic       r;
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            m_rbit(r);
            v = {v[6:0], r};
        end
        act_bus_q.push_back(int'(v));
        m_bit(nack);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   oe0;
        int   busy0;
        logic r;

        rst = 1'b0;
        wait_clk(4);
        chk("rst_sda_oe", int'(sda_oe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_reg_addr", int'(reg_addr), 0);
        chk("rst_reg_wdata", int'(reg_wdata), 0);
        chk("rst_reg_we", int'(reg_we), 0);
        chk("rst_reg_re", int'(reg_re), 0);
        rst = 1'b1;
        wait_clk(4);

        // 1: multi-byte write with auto-increment
        exp_bus_q.push_back(0); exp_bus_q.push_back(0);
        exp_bus_q.push_back(0); exp_bus_q.push_back(0);
        exp_wr_q.push_back({8'h10, 8'h5A});
        exp_wr_q.push_back({8'h11, 8'hC3});
        m_start();
        m_wbyte(8'hA0);
        chk("t1_busy_addressed", int'(busy), 1);
        m_wbyte(8'h10);
        m_wbyte(8'h5A);
        m_wbyte(8'hC3);
        m_stop();
        wait_clk(8);
        chk("t1_reg_addr", int'(reg_addr), 8'h12);
        chk("t1_reg_wdata", int'(reg_wdata), 8'hC3);
        chk("t1_busy_stop", int'(busy), 0);
        chk("t1_sda_oe", int'(sda_oe), 0);

        // 2: pointer write, repeated START, two-byte read ending in NACK
        exp_bus_q.push_back(0); exp_bus_q.push_back(0); exp_bus_q.push_back(0);
        exp_bus_q.push_back(8'hDF); exp_bus_q.push_back(8'hDE);
        exp_re_q.push_back(8'h20);
        exp_re_q.push_back(8'h21);
        m_start();
        m_wbyte(8'hA0);
        m_wbyte(8'h20);
        m_start();
        m_wbyte(8'hA1);
        m_rbyte(1'b0);
        m_rbyte(1'b1);
        wait_clk(4);
        chk("t2_busy_after_nack", int'(busy), 0);
        m_stop();
        wait_clk(8);
        chk("t2_reg_addr", int'(reg_addr), 8'h22);

        // 3: address mismatch is never ACKed
        oe0   = oe_hi_cnt;
        busy0 = busy_hi_cnt;
        exp_bus_q.push_back(1); exp_bus_q.push_back(1);
        m_start();
        m_wbyte(8'hA2);
        m_wbyte(8'h33);
        m_stop();
        wait_clk(8);
        chk("t3_sda_oe_clks", oe_hi_cnt - oe0, 0);
        chk("t3_busy_clks", busy_hi_cnt - busy0, 0);
        chk("t3_reg_addr", int'(reg_addr), 8'h22);

        // 4: pointer wrap 8'hFF -> 8'h00
        exp_bus_q.push_back(0); exp_bus_q.push_back(0);
        exp_bus_q.push_back(0); exp_bus_q.push_back(0);
        exp_wr_q.push_back({8'hFF, 8'h11});
        exp_wr_q.push_back({8'h00, 8'h22});
        m_start();
        m_wbyte(8'hA0);
        m_wbyte(8'hFF);
        m_wbyte(8'h11);
        m_wbyte(8'h22);
        m_stop();
        wait_clk(8);
        chk("t4_reg_addr", int'(reg_addr), 8'h01);

        // 5: STOP part-way through a data byte, then a fresh transaction
        exp_bus_q.push_back(0); exp_bus_q.push_back(0);
        m_start();
        m_wbyte(8'hA0);
        m_wbyte(8'h40);
        m_bit(1'b1);
        m_bit(1'b0);
        m_bit(1'b1);
        m_bit(1'b0);
        m_stop();
        wait_clk(8);
        chk("t5_sda_oe", int'(sda_oe), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_reg_addr", int'(reg_addr), 8'h40);
        exp_bus_q.push_back(0); exp_bus_q.push_back(0);
        m_start();
        m_wbyte(8'hA0);
        m_wbyte(8'h41);
        m_stop();
        wait_clk(8);
        chk("t5_reg_addr_next", int'(reg_addr), 8'h41);

        // 6: reset while the target drives a 0 read bit (data 8'hBE)
        exp_bus_q.push_back(0);
        exp_re_q.push_back(8'h41);
        m_start();
        m_wbyte(8'hA1);
        m_rbit(r);
        chk("t6_bit7", int'(r), 1);
        for (int i = 0; i < 4 * Q && sda_oe !== 1'b1; i++) wait_clk(1);
        chk("t6_driving_bit6", int'(sda_oe), 1);
        rst = 1'b0;
        wait_clk(1);
        chk("t6_sda_oe", int'(sda_oe), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_reg_addr", int'(reg_addr), 0);
        chk("t6_sda_bus", int'(sda_in), 1);
        rst = 1'b1;
        wait_clk(4);
        m_stop();
        wait_clk(8);
        exp_bus_q.push_back(0);
        m_start();
        m_wbyte(8'hA0);
        chk("t6_busy_recover", int'(busy), 1);
        m_stop();
        wait_clk(8);

        chk("wr_q_drained", exp_wr_q.size(), 0);
        chk("re_q_drained", exp_re_q.size(), 0);
        chk("bus_q_drained", exp_bus_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
